// File: rtl/car_parking_pkg.sv
// ----------------------------------------------------------------------------
// car_parking_pkg
// Shared types, constants and helpers for the parking-lot controller.
//   slot_w()   : width needed to hold a bay number 0..n (0 = "no bay")
//   LFSR_TAPS  : right-shift Galois feedback masks, indexed by code width
//   led_state_e: gate LED state
// ----------------------------------------------------------------------------
package car_parking_pkg;

    typedef enum logic [1:0] {
        LED_OFF,
        LED_GREEN,
        LED_RED
    } led_state_e;

    localparam int CODE_W_MIN = 4;
    localparam int CODE_W_MAX = 16;

    // Every mask has its top bit set, so the shift-and-xor step is a bijection
    // that maps only 0 to 0: a nonzero seed can never reach the all-zero state.
    // CODE_W=8 entry is x^8+x^6+x^5+x^4+1.
    localparam logic [15:0] LFSR_TAPS [CODE_W_MIN:CODE_W_MAX] = '{
        16'h000C, 16'h0014, 16'h0030, 16'h0060, 16'h00B8, 16'h0110, 16'h0240,
        16'h0500, 16'h0E08, 16'h1C80, 16'h3802, 16'h6000, 16'hD008
    };

    function automatic int slot_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/car_parking_ctrl_if.sv
// ----------------------------------------------------------------------------
// car_parking_ctrl_if
// Request/status bundle between the lot controller and its environment.
//   master: drives car_arrival, car_exit, exit_from, exit_code; observes status
//   slave : the controller side
// ----------------------------------------------------------------------------
interface car_parking_ctrl_if
    import car_parking_pkg::*;
#(
    parameter int NUM_SLOTS = 7,
    parameter int CODE_W    = 8
);
    localparam int SW = slot_w(NUM_SLOTS);

    logic                 car_arrival;
    logic                 car_exit;
    logic [SW-1:0]        exit_from;
    logic [CODE_W-1:0]    exit_code;

    logic [NUM_SLOTS-1:0] register;
    logic [SW-1:0]        available_slots;
    logic                 can_park;
    logic [CODE_W-1:0]    temp;
    logic [SW-1:0]        assigned_slot;
    logic                 exit_ok;
    logic                 exit_err;
    logic                 locked;
    logic                 g_led;
    logic                 r_led;

    modport master (
        output car_arrival, car_exit, exit_from, exit_code,
        input  register, available_slots, can_park, temp, assigned_slot,
               exit_ok, exit_err, locked, g_led, r_led
    );

    modport slave (
        input  car_arrival, car_exit, exit_from, exit_code,
        output register, available_slots, can_park, temp, assigned_slot,
               exit_ok, exit_err, locked, g_led, r_led
    );

endinterface

// File: rtl/park_code_lfsr.sv
// ----------------------------------------------------------------------------
// park_code_lfsr
// Free-running right-shift Galois LFSR used as the ticket code source.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset, loads SEED (forced nonzero)
//   code_o : current LFSR state, never 0
// ----------------------------------------------------------------------------
module park_code_lfsr
    import car_parking_pkg::*;
#(
    parameter int                CODE_W = 8,
    parameter logic [CODE_W-1:0] SEED   = CODE_W'(8'hA5)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic [CODE_W-1:0] code_o
);
    localparam logic [CODE_W-1:0] TAPS    = CODE_W'(LFSR_TAPS[CODE_W]);
    // A seed that truncates to zero would lock the register at zero.
    localparam logic [CODE_W-1:0] SEED_NZ = (SEED == '0) ? CODE_W'(1) : SEED;

    logic [CODE_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q[0]) begin
            lfsr_d = (lfsr_q >> 1) ^ TAPS;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= SEED_NZ;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign code_o = lfsr_q;

endmodule

// File: rtl/car_parking_ctrl.sv
// ----------------------------------------------------------------------------
// car_parking_ctrl
// Parking lot controller: allocates the lowest free bay on arrival, issues an
// LFSR ticket code per bay, validates exits against the stored code, locks
// the exit gate after MAX_FAILS consecutive bad exits, drives gate LEDs.
//   enable   : clock (rising edge)
//   gl_reset : synchronous active-high reset
//   bus      : request inputs and registered status outputs (slave side)
// ----------------------------------------------------------------------------
module car_parking_ctrl
    import car_parking_pkg::*;
#(
    parameter int          NUM_SLOTS = 7,
    parameter int          CODE_W    = 8,
    parameter logic [15:0] LFSR_SEED = 16'h00A5,
    parameter int          MAX_FAILS = 3,
    parameter int          LOCK_CYC  = 16,
    parameter int          LED_HOLD  = 4
) (
    input  logic              enable,
    input  logic              gl_reset,
    car_parking_ctrl_if.slave bus
);
    localparam int SW = slot_w(NUM_SLOTS);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int LW = $clog2(LOCK_CYC + 1);
    localparam int HW = $clog2(LED_HOLD + 1);

    logic [NUM_SLOTS-1:0] occ_q, occ_d;
    logic [CODE_W-1:0]    codes_q [NUM_SLOTS];
    logic [CODE_W-1:0]    codes_d [NUM_SLOTS];
    logic [SW-1:0]        avail_q, avail_d;
    logic                 can_q, can_d;
    logic [CODE_W-1:0]    temp_q, temp_d;
    logic [SW-1:0]        slot_q, slot_d;
    logic                 ok_q, ok_d;
    logic                 err_q, err_d;
    logic                 locked_q, locked_d;
    logic [FW-1:0]        fail_q, fail_d;
    logic [LW-1:0]        lock_cnt_q, lock_cnt_d;
    led_state_e           led_q, led_d;
    logic [HW-1:0]        led_cnt_q, led_cnt_d;

    logic [CODE_W-1:0]    lfsr_code;
    logic                 free_found;
    logic [SW-1:0]        free_idx;
    logic                 exit_occ;
    logic [CODE_W-1:0]    exit_stored;
    logic                 arr_ok, arr_ref, exit_acc, exit_rej;

    park_code_lfsr #(
        .CODE_W (CODE_W),
        .SEED   (LFSR_SEED[CODE_W-1:0])
    ) u_lfsr (
        .clk_i  (enable),
        .rst_i  (gl_reset),
        .code_o (lfsr_code)
    );

    // Lowest free bay: scanning downward leaves the lowest hit last.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!occ_q[i]) begin
                free_found = 1'b1;
                free_idx   = SW'(i);
            end
        end
    end

    // Bay lookup by compare rather than indexing: exit_from values of 0 or
    // above NUM_SLOTS match nothing and read as an empty bay.
    always_comb begin
        exit_occ    = 1'b0;
        exit_stored = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (bus.exit_from == SW'(i + 1)) begin
                exit_occ    = occ_q[i];
                exit_stored = codes_q[i];
            end
        end
    end

    assign arr_ok   = bus.car_arrival && free_found;
    assign arr_ref  = bus.car_arrival && !free_found;
    assign exit_acc = bus.car_exit && !locked_q && exit_occ && (exit_stored == bus.exit_code);
    assign exit_rej = bus.car_exit && !exit_acc;

    always_comb begin
        occ_d      = occ_q;
        codes_d    = codes_q;
        temp_d     = temp_q;
        slot_d     = slot_q;
        ok_d       = exit_acc;
        err_d      = exit_rej;
        fail_d     = fail_q;
        locked_d   = locked_q;
        lock_cnt_d = lock_cnt_q;
        led_d      = led_q;
        led_cnt_d  = led_cnt_q;

        // Allocation sees pre-exit occupancy, so the two updates never
        // touch the same bay in one cycle.
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (arr_ok && (free_idx == SW'(i))) begin
                occ_d[i]   = 1'b1;
                codes_d[i] = lfsr_code;
            end
            if (exit_acc && (bus.exit_from == SW'(i + 1))) begin
                occ_d[i]   = 1'b0;
                codes_d[i] = '0;
            end
        end

        if (arr_ok) begin
            temp_d = lfsr_code;
            slot_d = free_idx + SW'(1);
        end

        avail_d = avail_q - SW'(arr_ok) + SW'(exit_acc);
        can_d   = (avail_d != '0);

        // Fail count / lockout; rejects during lockout do not count.
        if (locked_q) begin
            if (lock_cnt_q == '0) begin
                locked_d = 1'b0;
                fail_d   = '0;
            end else begin
                lock_cnt_d = lock_cnt_q - LW'(1);
            end
        end else if (exit_acc) begin
            fail_d = '0;
        end else if (exit_rej) begin
            if (fail_q == FW'(MAX_FAILS - 1)) begin
                locked_d   = 1'b1;
                lock_cnt_d = LW'(LOCK_CYC - 1);
            end
            fail_d = fail_q + FW'(1);
        end

        // LED state machine; red takes priority, any event restarts the hold.
        if (arr_ref || exit_rej) begin
            led_d     = LED_RED;
            led_cnt_d = HW'(LED_HOLD - 1);
        end else if (arr_ok || exit_acc) begin
            led_d     = LED_GREEN;
            led_cnt_d = HW'(LED_HOLD - 1);
        end else if (led_q != LED_OFF) begin
            if (led_cnt_q == '0) begin
                led_d = LED_OFF;
            end else begin
                led_cnt_d = led_cnt_q - HW'(1);
            end
        end
    end

    always_ff @(posedge enable) begin
        if (gl_reset) begin
            occ_q      <= '0;
            codes_q    <= '{default: '0};
            avail_q    <= SW'(NUM_SLOTS);
            can_q      <= 1'b1;
            temp_q     <= '0;
            slot_q     <= '0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            locked_q   <= 1'b0;
            fail_q     <= '0;
            lock_cnt_q <= '0;
            led_q      <= LED_OFF;
            led_cnt_q  <= '0;
        end else begin
            occ_q      <= occ_d;
            codes_q    <= codes_d;
            avail_q    <= avail_d;
            can_q      <= can_d;
            temp_q     <= temp_d;
            slot_q     <= slot_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            locked_q   <= locked_d;
            fail_q     <= fail_d;
            lock_cnt_q <= lock_cnt_d;
            led_q      <= led_d;
            led_cnt_q  <= led_cnt_d;
        end
    end

    assign bus.register        = occ_q;
    assign bus.available_slots = avail_q;
    assign bus.can_park        = can_q;
    assign bus.temp            = temp_q;
    assign bus.assigned_slot   = slot_q;
    assign bus.exit_ok         = ok_q;
    assign bus.exit_err        = err_q;
    assign bus.locked          = locked_q;
    assign bus.g_led           = (led_q == LED_GREEN);
    assign bus.r_led           = (led_q == LED_RED);

endmodule

// File: tb/tb_car_parking_ctrl.sv
// ----------------------------------------------------------------------------
// tb_car_parking_ctrl
// Directed scoreboard bench: stimulus pushes the expected post-edge outputs,
// monitors compare them one edge later. Two DUTs: default (7 bays, 8-bit
// codes) and a 12-bay / 12-bit-code instance.
// ----------------------------------------------------------------------------
module tb_car_parking_ctrl;
    import car_parking_pkg::*;

    typedef struct {
        string       name;
        logic [63:0] reg_v;
        int          avail;
        bit          can;
        logic [15:0] temp;
        int          slot;
        bit          ok, err, lck, g, r;
    } exp_t;

    logic enable = 1'b0;
    logic rst_a  = 1'b1;
    logic rst_b  = 1'b1;
    always #5 enable = ~enable;

    car_parking_ctrl_if #(.NUM_SLOTS(7),  .CODE_W(8))  bus_a ();
    car_parking_ctrl_if #(.NUM_SLOTS(12), .CODE_W(12)) bus_b ();

    car_parking_ctrl #(
        .NUM_SLOTS(7), .CODE_W(8), .LFSR_SEED(16'h00A5),
        .MAX_FAILS(3), .LOCK_CYC(16), .LED_HOLD(4)
    ) dut_a (
        .enable(enable), .gl_reset(rst_a), .bus(bus_a.slave)
    );

    car_parking_ctrl #(
        .NUM_SLOTS(12), .CODE_W(12), .LFSR_SEED(16'h00A5),
        .MAX_FAILS(3), .LOCK_CYC(16), .LED_HOLD(4)
    ) dut_b (
        .enable(enable), .gl_reset(rst_b), .bus(bus_b.slave)
    );

    int checks = 0;
    int errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    bit use_b = 1'b0;

    // Expected architectural state, updated by the directed steps.
    logic [63:0] e_reg;
    int          e_avail;
    logic [15:0] e_temp;
    int          e_slot;
    logic [15:0] cap [0:15];

    // Reference code generators. 8-bit: x^8+x^6+x^5+x^4+1 in right-shift
    // Galois form (mask 0xB8); 12-bit: x^12+x^11+x^10+x^4+1 (mask 0xE08).
    logic [7:0]  m_a;
    logic [11:0] m_b;

    function automatic logic [7:0] lfsr8(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    function automatic logic [11:0] lfsr12(input logic [11:0] s);
        return s[0] ? ((s >> 1) ^ 12'hE08) : (s >> 1);
    endfunction

    always @(posedge enable) begin
        m_a <= rst_a ? 8'hA5  : lfsr8(m_a);
        m_b <= rst_b ? 12'h0A5 : lfsr12(m_b);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic compare(input exp_t e, input logic [63:0] rg, input logic [63:0] av,
                           input logic cp, input logic [63:0] tp, input logic [63:0] sl,
                           input logic ok, input logic er, input logic lk,
                           input logic g, input logic r);
        chk({e.name, "/register"},        rg, e.reg_v);
        chk({e.name, "/available_slots"}, av, 64'(e.avail));
        chk({e.name, "/can_park"},        64'(cp), 64'(e.can));
        chk({e.name, "/temp"},            tp, 64'(e.temp));
        chk({e.name, "/assigned_slot"},   sl, 64'(e.slot));
        chk({e.name, "/exit_ok"},         64'(ok), 64'(e.ok));
        chk({e.name, "/exit_err"},        64'(er), 64'(e.err));
        chk({e.name, "/locked"},          64'(lk), 64'(e.lck));
        chk({e.name, "/g_led"},           64'(g), 64'(e.g));
        chk({e.name, "/r_led"},           64'(r), 64'(e.r));
    endtask

    always begin : mon_a
        exp_t e;
        @(posedge enable);
        #1;
        if (q_a.size() != 0) begin
            e = q_a.pop_front();
            compare(e, 64'(bus_a.register), 64'(bus_a.available_slots), bus_a.can_park,
                    64'(bus_a.temp), 64'(bus_a.assigned_slot), bus_a.exit_ok,
                    bus_a.exit_err, bus_a.locked, bus_a.g_led, bus_a.r_led);
        end
    end

    always begin : mon_b
        exp_t e;
        @(posedge enable);
        #1;
        if (q_b.size() != 0) begin
            e = q_b.pop_front();
            compare(e, 64'(bus_b.register), 64'(bus_b.available_slots), bus_b.can_park,
                    64'(bus_b.temp), 64'(bus_b.assigned_slot), bus_b.exit_ok,
                    bus_b.exit_err, bus_b.locked, bus_b.g_led, bus_b.r_led);
        end
    end

    task automatic drive(input bit arr, input bit ex, input int from, input logic [15:0] code);
        if (use_b) begin
            bus_b.car_arrival = arr;
            bus_b.car_exit    = ex;
            bus_b.exit_from   = 4'(from);
            bus_b.exit_code   = 12'(code);
        end else begin
            bus_a.car_arrival = arr;
            bus_a.car_exit    = ex;
            bus_a.exit_from   = 3'(from);
            bus_a.exit_code   = 8'(code);
        end
    endtask

    task automatic push(input string nm, input bit ok, input bit err, input bit lck,
                        input bit g, input bit r);
        exp_t e;
        e.name  = nm;
        e.reg_v = e_reg;
        e.avail = e_avail;
        e.can   = (e_avail != 0);
        e.temp  = e_temp;
        e.slot  = e_slot;
        e.ok    = ok;
        e.err   = err;
        e.lck   = lck;
        e.g     = g;
        e.r     = r;
        if (use_b) q_b.push_back(e);
        else       q_a.push_back(e);
    endtask

    // One clock of stimulus. alloc = bay expected to be allocated (0: none),
    // freed = bay expected to be released (0: none).
    task automatic step(input bit arr, input bit ex, input int from, input logic [15:0] code,
                        input int alloc, input int freed,
                        input bit ok, input bit err, input bit lck, input bit g, input bit r,
                        input string nm);
        @(negedge enable);
        if (use_b) rst_b = 1'b0;
        else       rst_a = 1'b0;
        drive(arr, ex, from, code);
        if (alloc != 0) begin
            e_temp            = use_b ? 16'(m_b) : 16'(m_a);
            e_slot            = alloc;
            e_reg[alloc - 1]  = 1'b1;
            e_avail--;
            cap[alloc]        = e_temp;
        end
        if (freed != 0) begin
            e_reg[freed - 1] = 1'b0;
            e_avail++;
            cap[freed]       = '0;
        end
        push(nm, ok, err, lck, g, r);
        @(posedge enable);
    endtask

    // Reset with requests asserted to show that reset overrides them.
    task automatic do_reset(input string nm);
        @(negedge enable);
        if (use_b) rst_b = 1'b1;
        else       rst_a = 1'b1;
        drive(1'b1, 1'b1, 1, 16'h0000);
        e_reg   = '0;
        e_avail = use_b ? 12 : 7;
        e_temp  = '0;
        e_slot  = 0;
        for (int i = 0; i < 16; i++) cap[i] = '0;
        push(nm, 0, 0, 0, 0, 0);
        @(posedge enable);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] c6, bad;
        use_b = 1'b0;
        drive(0, 0, 0, 0);
        use_b = 1'b1;
        drive(0, 0, 0, 0);
        use_b = 1'b0;

        // Test 1: fill the lot
        do_reset("t1_reset");
        for (int i = 1; i <= 7; i++)
            step(1, 0, 0, 0, i, 0, 0, 0, 0, 1, 0, $sformatf("t1_arr%0d", i));

        // Test 2: arrival on a full lot, red LED hold
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "t2_full");
        for (int k = 1; k <= 4; k++)
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, (k <= 3), $sformatf("t2_hold%0d", k));

        // Test 3: exit bay 6, repeat it, then a clean exit of bay 7 clears the fail count
        c6 = cap[6];
        step(0, 1, 6, c6, 0, 6, 1, 0, 0, 1, 0, "t3_exit6");
        step(0, 1, 6, c6, 0, 0, 0, 1, 0, 0, 1, "t3_exit6_again");
        step(0, 1, 7, cap[7], 0, 7, 1, 0, 0, 1, 0, "t3_exit7");

        // Test 4: lockout after three bad codes on bay 2
        bad = cap[2] ^ 16'h0001;
        step(0, 1, 2, bad, 0, 0, 0, 1, 0, 0, 1, "t4_bad1");
        step(0, 1, 2, bad, 0, 0, 0, 1, 0, 0, 1, "t4_bad2");
        step(0, 1, 2, bad, 0, 0, 0, 1, 1, 0, 1, "t4_bad3");
        step(0, 1, 2, cap[2], 0, 0, 0, 1, 1, 0, 1, "t4_good_locked");
        for (int k = 2; k <= 16; k++)
            step(0, 0, 0, 0, 0, 0, 0, 0, (k <= 15), 0, (k <= 4), $sformatf("t4_lock%0d", k));
        step(0, 1, 2, cap[2], 0, 2, 1, 0, 0, 1, 0, "t4_good_after");

        // Test 5: refill, then simultaneous arrival and exit on a full lot
        step(1, 0, 0, 0, 2, 0, 0, 0, 0, 1, 0, "t5_arr2");
        step(1, 0, 0, 0, 6, 0, 0, 0, 0, 1, 0, "t5_arr6");
        step(1, 0, 0, 0, 7, 0, 0, 0, 0, 1, 0, "t5_arr7");
        step(1, 1, 3, cap[3], 0, 3, 1, 0, 0, 0, 1, "t5_arr_exit3");
        step(1, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0, "t5_arr3");

        // Test 6: reset mid-lockout with five bays occupied
        step(0, 1, 7, cap[7], 0, 7, 1, 0, 0, 1, 0, "t6_exit7");
        step(0, 1, 6, cap[6], 0, 6, 1, 0, 0, 1, 0, "t6_exit6");
        bad = cap[1] ^ 16'h0001;
        step(0, 1, 1, bad, 0, 0, 0, 1, 0, 0, 1, "t6_bad1");
        step(0, 1, 1, bad, 0, 0, 0, 1, 0, 0, 1, "t6_bad2");
        step(0, 1, 1, bad, 0, 0, 0, 1, 1, 0, 1, "t6_bad3");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, "t6_locked1");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, "t6_locked2");
        do_reset("t6_reset");
        step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, "t6_exit_bay0");
        @(negedge enable);
        drive(0, 0, 0, 0);

        // 12-bay / 12-bit configuration: fill, then one refused arrival
        use_b = 1'b1;
        do_reset("b_reset");
        for (int i = 1; i <= 12; i++)
            step(1, 0, 0, 0, i, 0, 0, 0, 0, 1, 0, $sformatf("b_arr%0d", i));
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "b_full");
        @(negedge enable);
        drive(0, 0, 0, 0);

        chk("scoreboard_drained", 64'(q_a.size() + q_b.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
